// File: rtl/register_pkg.sv
// Shared register-block types: readout FSM states and default bank geometry.
package register_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } rd_state_t;
endpackage

// File: rtl/register_bank.sv
// DEPTH x WIDTH storage, synchronous clear, one write port, combinational read with write-first bypass.
// Writes land on the clock edge; out-of-range write addresses are dropped.
module register_bank
  import register_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_in_range;
  logic             rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && wr_in_range) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A write on the same edge as a load must win, so the bypass precedes storage.
  always_comb begin
    rd_data = '0;
    if (wr_en && wr_in_range && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else if (rd_in_range) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/register_bank_reader.sv
// Register bank streamed out address 0 upward over valid/ready after a start; entry 0 valid the cycle after start.
// Beats hold while out_ready is low; done pulses one cycle after the last beat is accepted.
module register_bank_reader
  import register_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             out_last,
  output logic             done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rd_state_t        state_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             done_q;
  logic [WIDTH-1:0] out_data_q;
  logic [AW-1:0]    out_addr_q;
  logic [AW-1:0]    rd_addr_d;
  logic [WIDTH-1:0] rd_data;
  logic             accept;

  assign accept = out_valid_q && out_ready;

  // Next entry to load: 0 when launching, otherwise the one after the presented beat.
  always_comb begin
    rd_addr_d = '0;
    if (state_q != IDLE) begin
      rd_addr_d = out_addr_q + AW'(1);
    end
  end

  register_bank #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr_d),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= STREAM;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_addr_q  <= rd_addr_d;
            out_data_q  <= rd_data;
            out_last_q  <= (rd_addr_d == LAST_ADDR);
          end
        end
        STREAM: begin
          if (accept) begin
            if (out_addr_q == LAST_ADDR) begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_addr_q <= rd_addr_d;
              out_data_q <= rd_data;
              out_last_q <= (rd_addr_d == LAST_ADDR);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_register_bank_reader.sv
// Directed bench for register_bank_reader: fill, stream, backpressure, collisions, restart and reset abort.
module tb_register_bank_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_addr;
  logic       out_last;
  logic       done;

  int errors = 0;
  int checks = 0;

  register_bank_reader #(.WIDTH(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".valid"}, out_valid, 0);
    check({tag, ".last"}, out_last, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".data"}, out_data, 0);
    check({tag, ".addr"}, out_addr, 0);
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // One full readout. bp selects the ready pattern 1,0,0 repeating; an optional
  // write fires during cycle wr_cyc, and an extra start pulse during start_cyc.
  task automatic readout(input string tag, input logic [7:0] exp [8], input bit bp,
                         input int exp_stalls, input int wr_cyc, input logic [2:0] wa,
                         input logic [7:0] wd, input int start_cyc);
    int beat, cyc, stalls;
    bit held;
    logic [7:0] hd;
    logic [2:0] ha;
    logic hl;
    logic rdy;
    beat = 0; cyc = 1; stalls = 0; held = 0; hd = '0; ha = '0; hl = 0;
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".busy_first"}, busy, 1);
    check({tag, ".valid_first"}, out_valid, 1);
    while (cyc < 60 && !done) begin
      rdy = bp ? ((cyc - 1) % 3 == 0) : 1'b1;
      out_ready = rdy;
      wr_en = (cyc == wr_cyc); wr_addr = wa; wr_data = wd;
      start = (cyc == start_cyc);
      if (held) begin
        check({tag, ".hold_data"}, out_data, hd);
        check({tag, ".hold_addr"}, out_addr, ha);
        check({tag, ".hold_last"}, out_last, hl);
      end
      held = 0;
      if (out_valid) begin
        if (rdy) begin
          if (beat < 8) begin
            check($sformatf("%s.data%0d", tag, beat), out_data, exp[beat]);
            check($sformatf("%s.addr%0d", tag, beat), out_addr, beat);
            check($sformatf("%s.last%0d", tag, beat), out_last, (beat == 7));
          end
          beat++;
        end else begin
          stalls++;
          held = 1; hd = out_data; ha = out_addr; hl = out_last;
        end
      end
      step();
      cyc++;
    end
    wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
    check({tag, ".beats"}, beat, 8);
    check({tag, ".stalls"}, stalls, exp_stalls);
    check({tag, ".done_cycle"}, cyc, 9 + exp_stalls);
    check({tag, ".busy_at_done"}, busy, 1);
    check({tag, ".valid_at_done"}, out_valid, 0);
    step();
    check({tag, ".done_drop"}, done, 0);
    check({tag, ".busy_drop"}, busy, 0);
    check({tag, ".no_restart"}, out_valid, 0);
  endtask

  logic [7:0] zeros [8];
  logic [7:0] base [8];
  logic [7:0] col3 [8];
  logic [7:0] after55 [8];

  initial begin
    int done_seen;
    for (int i = 0; i < 8; i++) begin
      zeros[i] = 8'h00;
      base[i] = 8'h10 + 8'(i);
    end
    col3 = base; col3[1] = 8'h77; col3[3] = 8'hAA;
    after55 = col3; after55[1] = 8'h55;

    step(); step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();
    check_idle_outputs("idle");

    readout("zero", zeros, 0, 0, -1, 3'd0, 8'h00, -1);

    for (int i = 0; i < 8; i++) write(3'(i), 8'h10 + 8'(i));
    readout("fill", base, 0, 0, -1, 3'd0, 8'h00, -1);

    // Write 0x77 to addr 1 while beat 1 is stalled (cycle 2): held beat stays 0x11.
    readout("bp", base, 1, 14, 2, 3'd1, 8'h77, -1);

    // Cycle 3 loads addr 3: bypass presents 0xAA.
    readout("col3", col3, 0, 0, 3, 3'd3, 8'hAA, -1);

    // Write behind the stream plus a stray start mid-readout.
    readout("late_wr", col3, 0, 0, 4, 3'd1, 8'h55, 5);
    readout("after55", after55, 0, 0, -1, 3'd0, 8'h00, -1);

    // Reset after beat 4 has been accepted.
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    check_idle_outputs("abort");
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) done_seen++;
    end
    check("abort.no_done", done_seen, 0);
    readout("cleared", zeros, 0, 0, -1, 3'd0, 8'h00, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_bank_reader.md
# register_bank_reader

Register bank with a sequential readout engine. Software or upstream logic writes DEPTH entries of WIDTH bits through a simple write port. A `start` pulse streams every entry, address 0 upward, over a valid/ready interface. It is the read-side counterpart of the basic data register: it drains stored values to a downstream consumer, with backpressure.

## Interface
- `WIDTH`, 8, data width of each entry
- `DEPTH`, 8, number of entries (≥2)
- `AW`, `$clog2(DEPTH)`, address width (derived, not overridden)

- `clk` input 1: single clock, all logic on rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `wr_en` input 1: write strobe
- `wr_addr` input AW: write address
- `wr_data` input WIDTH: write data
- `start` input 1: begin a readout (single-cycle pulse or level)
- `busy` output 1: high from the cycle after an accepted `start` until `done`
- `out_valid` output 1: stream beat valid
- `out_ready` input 1: downstream accepts beat
- `out_data` output WIDTH: entry value
- `out_addr` output AW: entry address
- `out_last` output 1: high with the beat at address DEPTH-1
- `done` output 1: one-cycle pulse after the last beat is accepted

## Operation
- Reset (`rst_n`=0 at a clock edge):
  - all bank entries are cleared to 0.
  - `busy`, `out_valid`, `out_last` and `done` go to 0.
  - `out_data` and `out_addr` go to 0.
  - FSM returns to IDLE.
  - A reset during a readout aborts it; no `done` is produced.
- Writes: when `wr_en` is high, the entry at `wr_addr` is updated at the clock edge, in every state. A `wr_addr` ≥ DEPTH is ignored.
- FSM states IDLE, STREAM, DONE:
  - IDLE: `start`=1 → STREAM. `out_addr`←0, `out_data`←entry 0, `out_valid`←1, `busy`←1.
  - STREAM, beat accepted (`out_valid && out_ready`) and `out_addr`≠DEPTH-1: `out_addr` increments, `out_data` loads the next entry, `out_valid` stays 1.
  - STREAM, beat accepted at `out_addr`=DEPTH-1: `out_valid`←0 → DONE.
  - DONE: `done`=1 for exactly this cycle, `busy`←0 → IDLE.
- `start` is ignored outside IDLE.
- While `out_valid && !out_ready`, `out_data`, `out_addr` and `out_last` hold stable.
  - A write to the presented address does not alter the held beat.
- Write/read collision: if the cycle that loads entry k also writes entry k, the loaded `out_data` is `wr_data` (write-first bypass).
  - A write to an address already streamed does not affect the current readout.
- `out_last` = `out_valid && out_addr==DEPTH-1`, registered together with `out_addr`.

## Timing
- Latency: `start` sampled at edge N → `out_valid`=1 with entry 0 after edge N (visible cycle N+1).
- With `out_ready` held high, one beat per cycle.
  - DEPTH beats occupy cycles N+1..N+DEPTH.
  - `done` is high in cycle N+DEPTH+1.
  - `busy` falls after that cycle.
- Earliest next `start` is accepted in the cycle after `done`.
- Backpressure: each cycle with `out_ready`=0 extends the readout by one cycle. There is no combinational path from `out_ready` to `out_valid`.
- Write data is visible to a readout load on the same edge (bypass). Otherwise it is visible from the next cycle.

## Structure
- Shared package `register_pkg`:
  - FSM state enum `rd_state_t` (IDLE, STREAM, DONE).
  - Default WIDTH/DEPTH localparams, reused by `register_basic` benches.
- Sub-module `register_bank`:
  - DEPTH×WIDTH storage with a synchronous-reset write port.
  - Combinational read port with write-first bypass.
- `register_bank_reader` contains the FSM, address counter and output registers.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, release → all outputs 0. `start` with `out_ready`=1 → 8 beats of data 0x00, addr 0..7, `out_last` on addr 7, `done` one cycle later.
- Fill and stream:
  - write entry i = 0x10+i for i=0..7, then `start` with `out_ready`=1.
  - Expect data 0x10..0x17 on consecutive cycles starting 1 cycle after `start`.
  - Expect `done` in cycle N+9.
- Backpressure:
  - `out_ready` toggles 1,0,0,1,… during a readout.
  - Beats are held stable while stalled; no beat is lost or duplicated; `done` is delayed by exactly the number of stall cycles.
- Collisions:
  - write 0xAA to addr 3 in the cycle that loads addr 3 → beat 3 = 0xAA.
  - write 0x55 to addr 1 after beat 1 was sent → readout unaffected; next readout shows 0x55.
  - write 0x77 to the presented, stalled address → held beat is unchanged.
- `start` while busy: pulse `start` mid-stream → no restart, single `done`.
  - `start` in the cycle after `done` → new readout from addr 0.
- Reset mid-readout: assert `rst_n`=0 after beat 4 → next cycle all outputs 0, bank cleared, no `done` pulse.
